// File: rtl/apb_pwm_bank_if.sv
// APB3 bus bundle for the PWM bank: the master drives the request, the slave returns data and status.
interface apb_pwm_bank_if;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_pwm_bank.sv
// Bank of NUM_CH PWM channels with shadowed period/duty, plus a debounced hit sensor
// with sticky W1C status and a level interrupt, all behind one APB3 slave port.
module apb_pwm_bank #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 20,
    parameter int DEBOUNCE = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    apb_pwm_bank_if.slave     apb,
    input  logic              hit_data,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              HIT_INT
);

    localparam int         DB_W     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

    logic [2:0] ch_idx;
    logic [1:0] reg_sel;
    logic       ch_ok;
    logic       sel_status;
    logic       sel_hit_en;
    logic       mapped;
    logic       access;
    logic       wr_en;
    logic [31:0] rd_data;

    logic [CNT_W-1:0] period_v [NUM_CH];
    logic [CNT_W-1:0] duty_v   [NUM_CH];
    logic [CNT_W-1:0] cnt_v    [NUM_CH];
    logic [NUM_CH-1:0] en_v;
    logic [NUM_CH-1:0] inv_v;

    logic            sync1;
    logic            sync2;
    logic            deb_level;
    logic [DB_W-1:0] deb_cnt;
    logic            hit_rise;
    logic            hit_status;
    logic            hit_en;

    logic unused_bits;
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    // Channel n lives at n*0x10 below 0x80; the two global registers sit at 0x80/0x84.
    assign ch_idx     = apb.PADDR[6:4];
    assign reg_sel    = apb.PADDR[3:2];
    assign ch_ok      = !apb.PADDR[7] && ({1'b0, ch_idx} < NUM_CH_L);
    assign sel_status = (apb.PADDR[7:2] == 6'b100000);
    assign sel_hit_en = (apb.PADDR[7:2] == 6'b100001);
    assign mapped     = ch_ok || sel_status || sel_hit_en;
    assign access     = apb.PSEL && apb.PENABLE;
    assign wr_en      = access && apb.PWRITE && mapped;

    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = access && !mapped;
    assign apb.PRDATA  = (apb.PSEL && !apb.PWRITE) ? rd_data : 32'd0;

    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            logic [CNT_W-1:0] period_r;
            logic [CNT_W-1:0] duty_r;
            logic [CNT_W-1:0] per_a;
            logic [CNT_W-1:0] duty_a;
            logic [CNT_W-1:0] cnt;
            logic             en;
            logic             inv;
            logic             pwm_q;
            logic             ch_wr;
            logic             reload;

            assign ch_wr  = wr_en && ch_ok && (ch_idx == 3'(n));
            // Active copies only follow the shadows while idle or on the last count of a period,
            // so a mid-period update never produces a runt pulse.
            assign reload = !en || (per_a == '0) || (cnt == per_a - CNT_W'(1));

            always_ff @(posedge PCLK) begin
                if (PRESET) begin
                    period_r <= '0;
                    duty_r   <= '0;
                    per_a    <= '0;
                    duty_a   <= '0;
                    cnt      <= '0;
                    en       <= 1'b0;
                    inv      <= 1'b0;
                    pwm_q    <= 1'b0;
                end else begin
                    if (ch_wr && reg_sel == 2'd0) period_r <= apb.PWDATA[CNT_W-1:0];
                    if (ch_wr && reg_sel == 2'd1) duty_r   <= apb.PWDATA[CNT_W-1:0];
                    if (ch_wr && reg_sel == 2'd2) begin
                        en  <= apb.PWDATA[0];
                        inv <= apb.PWDATA[1];
                    end
                    if (reload) begin
                        per_a  <= period_r;
                        duty_a <= duty_r;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    pwm_q <= (en && (per_a != '0) && (cnt < duty_a)) ^ inv;
                end
            end

            assign pwm_out[n]  = pwm_q;
            assign period_v[n] = period_r;
            assign duty_v[n]   = duty_r;
            assign cnt_v[n]    = cnt;
            assign en_v[n]     = en;
            assign inv_v[n]    = inv;
        end
    endgenerate

    always_comb begin
        rd_data = 32'd0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (ch_ok && ch_idx == 3'(n)) begin
                case (reg_sel)
                    2'd0:    rd_data = 32'(period_v[n]);
                    2'd1:    rd_data = 32'(duty_v[n]);
                    2'd2:    rd_data = {30'd0, inv_v[n], en_v[n]};
                    default: rd_data = 32'(cnt_v[n]);
                endcase
            end
        end
        if (sel_status) rd_data = {31'd0, hit_status};
        if (sel_hit_en) rd_data = {31'd0, hit_en};
    end

    // The debounced level only flips after the synced input has disagreed with it
    // for DEBOUNCE consecutive cycles; the flip to 1 is the event that sets status.
    assign hit_rise = sync2 && !deb_level && (deb_cnt == DB_W'(DEBOUNCE - 1));

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            deb_level  <= 1'b0;
            deb_cnt    <= '0;
            hit_status <= 1'b0;
            hit_en     <= 1'b0;
            HIT_INT    <= 1'b0;
        end else begin
            sync1 <= hit_data;
            sync2 <= sync1;
            if (sync2 != deb_level) begin
                if (deb_cnt == DB_W'(DEBOUNCE - 1)) begin
                    deb_level <= sync2;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DB_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
            if (wr_en && sel_hit_en) hit_en <= apb.PWDATA[0];
            if (hit_rise) begin
                hit_status <= 1'b1;
            end else if (wr_en && sel_status && apb.PWDATA[0]) begin
                hit_status <= 1'b0;
            end
            HIT_INT <= hit_status && hit_en;
        end
    end

endmodule
